mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameters: ADDR_W, 16, word-address width to cpu_bram; DATA_W, 32, data width (fixed 32, 4 byte lanes).
REQ-002 SHALL have ports (clock and reset first):
 clock  input  1  single clock, all logic rising-edge.
 rst  input  1  reset, synchronous, active-high.
 req_valid  input  1  CPU request present.
 req_ready  output  1  unit can accept a request.
 req_we  input  1  1=store, 0=load.
 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
 req_addr  input  ADDR_W+2  byte address; word index = req_addr[ADDR_W+1:2].
 req_wdata  input  32  store data, right-justified.
 resp_valid  output  1  one-cycle completion pulse.
 resp_rdata  output  32  aligned, extended load data; 0 for stores and errors.
 resp_misaligned  output  1  request rejected, qualified by resp_valid.
 mem_address  output  ADDR_W  to cpu_bram address.
 mem_byteena  output  4  to cpu_bram byteena.
 mem_data  output  32  to cpu_bram data.
 mem_rden  output  1  to cpu_bram rden.
 mem_wren  output  1  to cpu_bram wren.
 mem_q  input  32  from cpu_bram q; valid the cycle after the mem_rden cycle.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; req_ready = (state==IDLE) and not rst.
REQ-004 IDLE: on req_valid SHALL latch all req_* fields; legal request -> ISSUE; misaligned/illegal -> DONE with resp_misaligned=1, no memory access.
REQ-005 Misaligned SHALL mean: half with addr[0]=1; word with addr[1:0]!=00; req_size=11 regardless of address.
REQ-006 ISSUE: mem_wren (store) or mem_rden (load) SHALL be high for exactly this one cycle; all mem_* outputs registered; store -> DONE, load -> WAIT.
REQ-007 mem_byteena SHALL be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111; 0000 when no strobe.
REQ-008 mem_data SHALL replicate req_wdata[7:0] x4 for byte, req_wdata[15:0] x2 for half, req_wdata for word.
REQ-009 WAIT: SHALL capture mem_q, select lane by latched addr[1:0]/size, extend per req_unsigned into resp_rdata; -> DONE.
REQ-010 DONE: resp_valid=1 for exactly one cycle, resp_rdata/resp_misaligned held stable that cycle; -> IDLE; no backpressure on response.
REQ-011 Latency from accept edge T: misaligned resp_valid at T+1; store mem_wren at T+1, resp_valid at T+2; load mem_rden at T+1, resp_valid at T+3.
REQ-012 req_valid outside IDLE SHALL be ignored (not latched); back-to-back requests accepted the cycle after DONE.
REQ-013 mem_rden and mem_wren SHALL never be high together.

Reset
REQ-014 On rst high at any clock edge, including mid-operation, state SHALL become IDLE and in-flight request be dropped with no resp_valid.
REQ-015 Reset values: resp_valid 0, resp_rdata 0, resp_misaligned 0, mem_rden 0, mem_wren 0, mem_address 0, mem_byteena 0000, mem_data 0; req_ready 0 while rst high, 1 first cycle after.

Structure
REQ-016 mem_access_pkg SHALL hold the size enum (BYTE/HALF/WORD/ILLEGAL), FSM state enum, and the byteena-generation function.
REQ-017 Load lane selection and extension SHALL be one combinational sub-module, lsu_load_align (inputs mem_q, addr[1:0], size, unsigned; output 32-bit data).

Verification (bench instantiates mem_access_unit driving real cpu_bram)
REQ-018 Store word 0xA0000003 at 0x000C -> T+1: mem_wren=1, mem_address=0x0003, mem_byteena=1111; resp_valid at T+2; word load at 0x000C returns 0xA0000003 at T+3.
REQ-019 Store half 0xBEEF at 0x0028 -> mem_byteena=0011, mem_data=0xBEEFBEEF, mem_address=0x000A; signed byte load at 0x0029 -> 0xFFFFFFBE; unsigned -> 0x000000BE.
REQ-020 Store half 0x1234 at 0x002E -> mem_byteena=1100, mem_address=0x000B; unsigned half load at 0x002E -> 0x00001234.
REQ-021 Word load at 0x0002, half store at 0x0005, size=11 at 0x0000 -> each resp_valid at T+1, resp_misaligned=1, resp_rdata=0, mem_rden/mem_wren never high.
REQ-022 Load accepted, rst pulsed at T+2 (WAIT) -> no resp_valid, mem strobes 0, req_ready=1 the cycle after rst falls; following word load completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the CPU load/store unit: access sizes, FSM states,
// byte-lane strobe generation and store-data lane replication.
package mem_access_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Size 11 is always rejected, whatever the address.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            BYTE:    mis = 1'b0;
            HALF:    mis = addr_lo[0];
            WORD:    mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byteena_gen(input size_e size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << addr_lo;
            HALF:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // The RAM only writes enabled lanes, so copying the data into every lane
    // avoids a shifter keyed on the address.
    function automatic logic [31:0] wdata_replicate(input size_e size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            BYTE:    d = {4{wdata[7:0]}};
            HALF:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half-word lane of a RAM read word and
// sign- or zero-extends it to 32 bits.
module lsu_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] mem_q_i,
    input  logic [1:0]  addr_lo_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        ext_bit;

    always_comb begin
        byte_sel = mem_q_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = mem_q_i[7:0];
            2'd1:    byte_sel = mem_q_i[15:8];
            2'd2:    byte_sel = mem_q_i[23:16];
            default: byte_sel = mem_q_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? mem_q_i[31:16] : mem_q_i[15:0];

        ext_bit = 1'b0;
        data_o  = mem_q_i;
        case (size_i)
            BYTE: begin
                ext_bit = ~unsigned_i & byte_sel[7];
                data_o  = {{24{ext_bit}}, byte_sel};
            end
            HALF: begin
                ext_bit = ~unsigned_i & half_sel[15];
                data_o  = {{16{ext_bit}}, half_sel};
            end
            default: data_o = mem_q_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store unit in front of a single-port BRAM with one-cycle read latency.
// Handshake: a request is taken on a clock edge where req_valid && req_ready; resp_valid is a one-cycle pulse with no backpressure.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W+1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_misaligned,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [3:0]          mem_byteena,
    output logic [DATA_W-1:0]   mem_data,
    output logic                mem_rden,
    output logic                mem_wren,
    input  logic [DATA_W-1:0]   mem_q
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    size_e               size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          addr_lo_q, addr_lo_d;

    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [3:0]          mem_byteena_q, mem_byteena_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                mem_rden_q, mem_rden_d;
    logic                mem_wren_q, mem_wren_d;

    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_mis_q, resp_mis_d;

    size_e               req_size_e;
    logic [DATA_W-1:0]   load_data;

    assign req_size_e = size_e'(req_size);

    lsu_load_align u_align (
        .mem_q_i    (mem_q),
        .addr_lo_i  (addr_lo_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (load_data)
    );

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        uns_d         = uns_q;
        addr_lo_d     = addr_lo_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_byteena_d = 4'b0000;
        mem_rden_d    = 1'b0;
        mem_wren_d    = 1'b0;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = '0;
        resp_mis_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    size_d    = req_size_e;
                    uns_d     = req_unsigned;
                    addr_lo_d = req_addr[1:0];
                    if (is_misaligned(req_size_e, req_addr[1:0])) begin
                        // Rejected requests skip the RAM and answer next cycle.
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                    end else begin
                        // Strobes are loaded here so they are registered during ISSUE.
                        state_d       = ISSUE;
                        mem_address_d = req_addr[ADDR_W+1:2];
                        mem_byteena_d = byteena_gen(req_size_e, req_addr[1:0]);
                        mem_rden_d    = ~req_we;
                        mem_wren_d    = req_we;
                        if (req_we) begin
                            mem_data_d = wdata_replicate(req_size_e, req_wdata);
                        end
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d      = DONE;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            size_q        <= BYTE;
            uns_q         <= 1'b0;
            addr_lo_q     <= 2'b00;
            mem_address_q <= '0;
            mem_byteena_q <= 4'b0000;
            mem_data_q    <= '0;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_mis_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            addr_lo_q     <= addr_lo_d;
            mem_address_q <= mem_address_d;
            mem_byteena_q <= mem_byteena_d;
            mem_data_q    <= mem_data_d;
            mem_rden_q    <= mem_rden_d;
            mem_wren_q    <= mem_wren_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_mis_q    <= resp_mis_d;
        end
    end

    assign req_ready       = (state_q == IDLE) && !rst;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign mem_address     = mem_address_q;
    assign mem_byteena     = mem_byteena_q;
    assign mem_data        = mem_data_q;
    assign mem_rden        = mem_rden_q;
    assign mem_wren        = mem_wren_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a small BRAM model with one-cycle read latency,
// table vectors with fixed expectations, hand sequences and random traffic against a reference memory.
module tb_mem_access_unit;

    localparam int ADDR_W = 16;

    logic                clock = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_we = 1'b0;
    logic [1:0]          req_size = 2'b00;
    logic                req_unsigned = 1'b0;
    logic [ADDR_W+1:0]   req_addr = '0;
    logic [31:0]         req_wdata = '0;
    logic                resp_valid;
    logic [31:0]         resp_rdata;
    logic                resp_misaligned;
    logic [ADDR_W-1:0]   mem_address;
    logic [3:0]          mem_byteena;
    logic [31:0]         mem_data;
    logic                mem_rden;
    logic                mem_wren;
    logic [31:0]         mem_q = '0;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clock           (clock),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_address     (mem_address),
        .mem_byteena     (mem_byteena),
        .mem_data        (mem_data),
        .mem_rden        (mem_rden),
        .mem_wren        (mem_wren),
        .mem_q           (mem_q)
    );

    // ---------------- BRAM model (64 words) ----------------
    logic        ram_clear = 1'b1;
    logic [31:0] ram [0:63];

    always @(posedge clock) begin
        if (ram_clear) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
        end else begin
            if (mem_wren) begin
                for (int l = 0; l < 4; l++)
                    if (mem_byteena[l]) ram[mem_address[5:0]][8*l +: 8] <= mem_data[8*l +: 8];
            end
            if (mem_rden) mem_q <= ram[mem_address[5:0]];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:15];

    function automatic logic model_mis(input logic [1:0] size, input logic [1:0] lo);
        return (size == 2'd3) || (size == 2'd2 && lo != 2'd0) || (size == 2'd1 && lo[0]);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [ADDR_W+1:0] addr);
        logic [31:0] v;
        v = ref_mem[addr[5:2]] >> (8 * addr[1:0]);
        if (size == 2'd0) return uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (size == 2'd1) return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [ADDR_W+1:0] addr,
                               input logic [31:0] wdata);
        logic en;
        logic [7:0] b;
        for (int l = 0; l < 4; l++) begin
            if (size == 2'd0) begin
                en = (l == int'(addr[1:0]));
                b  = wdata[7:0];
            end else if (size == 2'd1) begin
                en = ((l / 2) == int'(addr[1]));
                b  = wdata[8*(l%2) +: 8];
            end else begin
                en = 1'b1;
                b  = wdata[8*l +: 8];
            end
            if (en) ref_mem[addr[5:2]][8*l +: 8] = b;
        end
    endtask

    // ---------------- checks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response pops one expected {misaligned, rdata}.
    always @(negedge clock) begin
        logic [32:0] e;
        if (resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp actual=%b/%h expected=none at %0t",
                         resp_misaligned, resp_rdata, $time);
            end else begin
                e = exp_q.pop_front();
                if ({resp_misaligned, resp_rdata} !== e) begin
                    errors++;
                    $display("FAIL resp actual=%b/%h expected=%b/%h at %0t",
                             resp_misaligned, resp_rdata, e[32], e[31:0], $time);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (mem_rden && mem_wren) begin
            checks++;
            errors++;
            $display("FAIL strobe_overlap actual=rden1_wren1 expected=exclusive at %0t", $time);
        end
    end

    // ---------------- drivers ----------------
    // Returns at the falling edge of the cycle after the accept edge (T+1).
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [ADDR_W+1:0] addr, input logic [31:0] wdata,
                        input logic push, input logic [32:0] exp);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        if (push) exp_q.push_back(exp);
        if (we && !model_mis(size, addr[1:0])) model_store(size, addr, wdata);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(negedge clock);
        req_valid    = 1'b0;
        req_wdata    = $urandom;
    endtask

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [ADDR_W+1:0] addr, input logic [31:0] wdata,
                           input logic exp_mis, input logic [31:0] exp_rdata,
                           input logic check_mem, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
        int lat;
        send(we, size, uns, addr, wdata, 1'b1, {exp_mis, exp_rdata});
        chk("t1_wren", {31'b0, mem_wren}, {31'b0, !exp_mis && we});
        chk("t1_rden", {31'b0, mem_rden}, {31'b0, !exp_mis && !we});
        if (check_mem && !exp_mis) begin
            chk("t1_address", {16'b0, mem_address}, {16'b0, addr[ADDR_W+1:2]});
            chk("t1_byteena", {28'b0, mem_byteena}, {28'b0, exp_be});
            if (we) chk("t1_mem_data", mem_data, exp_data);
        end
        lat = 0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clock);
            if (resp_valid && lat == 0) lat = k;
        end
        chk("latency", lat, exp_mis ? 32'd1 : (we ? 32'd2 : 32'd3));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic        exp_mis;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int n;
        logic we, uns, mis;
        logic [1:0] size;
        logic [17:0] addr;
        logic [31:0] wd;

        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 18'h000C, 32'hA0000003, 1'b0, 32'h0,        4'b1111, 32'hA0000003};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 18'h000C, 32'h0,        1'b0, 32'hA0000003, 4'b1111, 32'h0};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 18'h0028, 32'h0000BEEF, 1'b0, 32'h0,        4'b0011, 32'hBEEFBEEF};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 18'h0029, 32'h0,        1'b0, 32'hFFFFFFBE, 4'b0010, 32'h0};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 18'h0029, 32'h0,        1'b0, 32'h000000BE, 4'b0010, 32'h0};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 18'h002E, 32'h00001234, 1'b0, 32'h0,        4'b1100, 32'h12341234};
        tbl[6]  = '{1'b0, 2'd1, 1'b1, 18'h002E, 32'h0,        1'b0, 32'h00001234, 4'b1100, 32'h0};
        tbl[7]  = '{1'b0, 2'd2, 1'b0, 18'h0002, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 18'h0005, 32'h0000CAFE, 1'b1, 32'h0,        4'b0000, 32'h0};
        tbl[9]  = '{1'b0, 2'd3, 1'b0, 18'h0000, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0};
        tbl[10] = '{1'b1, 2'd0, 1'b0, 18'h0013, 32'h1111115A, 1'b0, 32'h0,        4'b1000, 32'h5A5A5A5A};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 18'h0010, 32'h0,        1'b0, 32'h5A000000, 4'b1111, 32'h0};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 18'h0030, 32'hFFFF8001, 1'b0, 32'h0,        4'b0011, 32'h80018001};
        tbl[13] = '{1'b0, 2'd1, 1'b0, 18'h0030, 32'h0,        1'b0, 32'hFFFF8001, 4'b0011, 32'h0};
        tbl[14] = '{1'b0, 2'd0, 1'b1, 18'h0031, 32'h0,        1'b0, 32'h00000080, 4'b0010, 32'h0};

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_mis", {31'b0, resp_misaligned}, 32'd0);
        chk("rst_strobes", {30'b0, mem_rden, mem_wren}, 32'd0);
        chk("rst_address", {16'b0, mem_address}, 32'd0);
        chk("rst_byteena", {28'b0, mem_byteena}, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        rst = 1'b0;
        ram_clear = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        // Table vectors
        foreach (tbl[i]) begin
            run_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                    tbl[i].exp_mis, tbl[i].exp_rdata, 1'b1, tbl[i].exp_be, tbl[i].exp_data);
        end
        wait_drain();

        // Back-to-back: next request accepted in the cycle after DONE
        send(1'b1, 2'd0, 1'b0, 18'h0004, 32'h00000077, 1'b1, 33'h0);
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("b2b_ready_delay", n, 32'd2);
        send(1'b0, 2'd0, 1'b1, 18'h0004, 32'h0, 1'b1, {1'b0, 32'h00000077});
        wait_drain();

        // Reset while a load sits in WAIT: dropped with no response
        send(1'b0, 2'd2, 1'b0, 18'h000C, 32'h0, 1'b0, 33'h0);
        chk("rstmid_t1_rden", {31'b0, mem_rden}, 32'd1);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        chk("rstmid_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rstmid_strobes", {30'b0, mem_rden, mem_wren}, 32'd0);
        chk("rstmid_ready_in_rst", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clock);
        chk("rstmid_ready_after", {31'b0, req_ready}, 32'd1);
        run_req(1'b0, 2'd2, 1'b0, 18'h000C, 32'h0, 1'b0, 32'hA0000003, 1'b1, 4'b1111, 32'h0);
        wait_drain();

        // Random traffic against the reference memory
        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = 18'($urandom_range(0, 63));
            wd   = $urandom;
            mis  = model_mis(size, addr[1:0]);
            run_req(we, size, uns, addr, wd, mis,
                    (mis || we) ? 32'h0 : model_load(size, uns, addr), 1'b0, 4'b0, 32'h0);
        end
        wait_drain();

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
